pmp_csr_ctrl: RTL and testbench
===============================

# pmp_csr_ctrl

Programming-side front end of the PMP checker. Owns the per-channel pmpcfg/pmpaddr state, accepts CSR read/write requests over a valid/ready handshake, enforces lock and reserved-encoding rules, and precomputes the NAPOT mask per channel. Its outputs drive the checker's configuration, address and mask vectors directly. Writes are flagged as unsettled until the mask is consistent.

## Interface
- PMP_CHANNEL_NUM, 32, number of PMP channels (power of two, 2..64)
- ADDR_WIDTH, 32, width of pmpaddr and NAPOT mask
- IDX_W, $clog2(PMP_CHANNEL_NUM), channel index width (derived)

One clock; reset is asynchronous and active-low.

- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- csr_req_vld  in  1  request valid
- csr_req_rdy  out  1  request ready
- csr_req_wr  in  1  1=write, 0=read
- csr_req_sel  in  1  0=pmpcfg, 1=pmpaddr
- csr_req_idx  in  IDX_W  channel index
- csr_req_wdata  in  ADDR_WIDTH  write data; cfg uses [7:0]
- csr_rsp_vld  out  1  response valid
- csr_rsp_rdy  in  1  response accepted
- csr_rsp_rdata  out  ADDR_WIDTH  read data; cfg zero-extended from 8 bits; 0 for writes
- csr_rsp_ignored  out  1  write dropped due to lock
- v_pmp_cfg  out  pmp_cfg_t[PMP_CHANNEL_NUM]  per-channel cfg {L[7], 0[6:5], A[4:3], X[2], W[1], R[0]}
- v_pmp_addr  out  ADDR_WIDTH[PMP_CHANNEL_NUM]  per-channel address
- v_pmp_napot_mask  out  ADDR_WIDTH[PMP_CHANNEL_NUM]  per-channel NAPOT mask
- pmp_cfg_stable  out  1  1 when all outputs mutually consistent

## Operation
- FSM states: IDLE, EXEC, MASK, RSP.
- IDLE: csr_req_rdy=1. On vld&rdy, capture wr/sel/idx/wdata and go to EXEC. If wr=1, clear pmp_cfg_stable.
- EXEC: csr_req_rdy=0.
  - Read: capture rdata and go to RSP.
  - Write, not locked: update the register and go to MASK.
  - Write, locked: leave state unchanged, set ignored, set pmp_cfg_stable=1, go to RSP.
- MASK: recompute v_pmp_napot_mask[idx], set pmp_cfg_stable=1, go to RSP. Every non-ignored write passes through MASK, regardless of A.
- RSP: csr_rsp_vld=1 with rdata/ignored held stable. On csr_rsp_rdy, go to IDLE. One request outstanding at a time.
- Lock rules:
  - cfg[i] write is ignored if cfg[i].L=1.
  - addr[i] write is ignored if cfg[i].L=1, or if i<N-1 with cfg[i+1].L=1 and cfg[i+1].A=TOR(2'b01).
- Cfg write legalisation: bits [6:5] are forced to 0. If W=1 and R=0, W is stored as 0.
- NAPOT mask for channel i:
  - A=NA4(2'b10): all ones.
  - Otherwise: ~(addr ^ (addr + 1)), computed in ADDR_WIDTH bits with wrap-around. addr=all-ones gives mask 0.
  - Mask is recomputed after cfg[i] writes too, using the current addr[i].
- Reset values:
  - all cfg=0, addr=0, mask=all ones
  - pmp_cfg_stable=1, csr_req_rdy=1 (state IDLE)
  - csr_rsp_vld=0, csr_rsp_rdata=0, csr_rsp_ignored=0
- Reset mid-operation: the in-flight request and any pending response are discarded, and all registers return to reset values.

## Timing
- Request accepted at the end of cycle 0.
- Read: EXEC in cycle 1; csr_rsp_vld=1 from cycle 2.
- Write, unlocked:
  - new cfg/addr visible on outputs in cycle 2
  - new mask and pmp_cfg_stable=1 in cycle 3
  - csr_rsp_vld=1 from cycle 3
  - pmp_cfg_stable=0 during cycles 1–2
- Write, locked: pmp_cfg_stable=0 in cycle 1 only; response in cycle 2.
- Response holds until csr_rsp_rdy. The earliest next accept is the cycle after the response handshake, so throughput is at most one request per 3 (read) or 4 (write) cycles.
- All outputs are registered. csr_req_rdy is a state decode.

## Test plan
- Reset, then read addr[5] → rsp_vld in cycle 2 with rdata=0, ignored=0. During reset, all masks=0xFFFF_FFFF and pmp_cfg_stable=1.
- Write addr[3]=0x0000_00FF, then cfg[3]=0x1F (NAPOT, RWX) → v_pmp_addr[3]=0xFF in cycle 2. After the cfg write, mask[3]=0xFFFF_FE00 and cfg[3]=0x1F. Stable low exactly during cycles 1–2 of each write.
- Write cfg[2]=0x82 (L=1, W=1, R=0) → stored as 0x80. Then write cfg[2]=0x07 → ignored=1, cfg unchanged. Then write addr[2]=0x1234 → ignored=1.
- Write cfg[4]=0x88 (L=1, TOR), then addr[3]=0x500 → ignored=1, addr[3] unchanged. Write addr[4]=0x600 → ignored=1.
- Write addr[0]=0xFFFF_FFFF → mask[0]=0x0000_0000. Write cfg[0]=0x17 (NA4) → mask[0]=0xFFFF_FFFF.
- Hold csr_rsp_rdy=0 for 5 cycles after a read → rsp_vld and rdata stay stable and csr_req_rdy stays 0. Assert rst_n=0 during MASK → all outputs return to reset values asynchronously, and no response is issued after reset.

Source files
------------

// File: rtl/pmp_csr_ctrl_if.sv
// CSR request/response channel between the PMP programming master and pmp_csr_ctrl.
// Both directions use valid/ready handshakes, and only one request is outstanding at a time.
interface pmp_csr_ctrl_if #(
    parameter int IDX_W      = 5,
    parameter int ADDR_WIDTH = 32
);
    logic                  csr_req_vld;
    logic                  csr_req_rdy;
    logic                  csr_req_wr;
    logic                  csr_req_sel;
    logic [IDX_W-1:0]      csr_req_idx;
    logic [ADDR_WIDTH-1:0] csr_req_wdata;
    logic                  csr_rsp_vld;
    logic                  csr_rsp_rdy;
    logic [ADDR_WIDTH-1:0] csr_rsp_rdata;
    logic                  csr_rsp_ignored;

    modport master (
        output csr_req_vld, csr_req_wr, csr_req_sel, csr_req_idx, csr_req_wdata, csr_rsp_rdy,
        input  csr_req_rdy, csr_rsp_vld, csr_rsp_rdata, csr_rsp_ignored
    );

    modport slave (
        input  csr_req_vld, csr_req_wr, csr_req_sel, csr_req_idx, csr_req_wdata, csr_rsp_rdy,
        output csr_req_rdy, csr_rsp_vld, csr_rsp_rdata, csr_rsp_ignored
    );
endinterface

// File: rtl/pmp_csr_ctrl.sv
// This block holds the PMP cfg/addr state and the per-channel NAPOT mask, and it is programmed through the CSR channel.
// A read responds in cycle 2, an unlocked write in cycle 3 and a locked write in cycle 2; the response is held until csr_rsp_rdy.
module pmp_csr_ctrl #(
    parameter  int PMP_CHANNEL_NUM = 32,
    parameter  int ADDR_WIDTH      = 32,
    localparam int IDX_W           = $clog2(PMP_CHANNEL_NUM)
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    pmp_csr_ctrl_if.slave                               csr,
    output logic [PMP_CHANNEL_NUM-1:0][7:0]             v_pmp_cfg,
    output logic [PMP_CHANNEL_NUM-1:0][ADDR_WIDTH-1:0]  v_pmp_addr,
    output logic [PMP_CHANNEL_NUM-1:0][ADDR_WIDTH-1:0]  v_pmp_napot_mask,
    output logic                                        pmp_cfg_stable
);
    typedef struct packed {
        logic       l;
        logic [1:0] rsvd;
        logic [1:0] a;
        logic       x;
        logic       w;
        logic       r;
    } pmp_cfg_t;

    typedef enum logic [1:0] {IDLE, EXEC, MASK, RSP} state_t;

    state_t                                       state_q;
    logic                                         wr_q;
    logic                                         sel_q;
    logic [IDX_W-1:0]                             idx_q;
    logic [ADDR_WIDTH-1:0]                        wdata_q;
    pmp_cfg_t [PMP_CHANNEL_NUM-1:0]               cfg_q;
    logic [PMP_CHANNEL_NUM-1:0][ADDR_WIDTH-1:0]   addr_q;
    logic [PMP_CHANNEL_NUM-1:0][ADDR_WIDTH-1:0]   mask_q;
    logic                                         stable_q;
    logic [ADDR_WIDTH-1:0]                        rdata_q;
    logic                                         ignored_q;

    pmp_cfg_t              cur_cfg;
    pmp_cfg_t              nxt_cfg;
    pmp_cfg_t              wcfg_d;
    logic [IDX_W-1:0]      idx_nxt;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH-1:0] mask_d;
    logic [ADDR_WIDTH-1:0] rdata_d;
    logic                  locked_d;

    always_comb begin
        cur_cfg  = cfg_q[idx_q];
        idx_nxt  = idx_q + IDX_W'(1);
        nxt_cfg  = cfg_q[idx_nxt];
        cur_addr = addr_q[idx_q];
        // A TOR entry above also uses this address as its lower bound, so locking that entry freezes this address too.
        if (sel_q) begin
            locked_d = cur_cfg.l |
                       ((idx_q != IDX_W'(PMP_CHANNEL_NUM - 1)) & nxt_cfg.l & (nxt_cfg.a == 2'b01));
        end else begin
            locked_d = cur_cfg.l;
        end
        wcfg_d      = wdata_q[7:0];
        wcfg_d.rsvd = 2'b00;
        if (wcfg_d.w & ~wcfg_d.r) begin
            wcfg_d.w = 1'b0;
        end
        mask_d  = (cur_cfg.a == 2'b10) ? '1 : ~(cur_addr ^ (cur_addr + ADDR_WIDTH'(1)));
        rdata_d = sel_q ? cur_addr : ADDR_WIDTH'(cur_cfg);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_q      <= 1'b0;
            sel_q     <= 1'b0;
            idx_q     <= '0;
            wdata_q   <= '0;
            cfg_q     <= '0;
            addr_q    <= '0;
            mask_q    <= '1;
            stable_q  <= 1'b1;
            rdata_q   <= '0;
            ignored_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (csr.csr_req_vld) begin
                        wr_q    <= csr.csr_req_wr;
                        sel_q   <= csr.csr_req_sel;
                        idx_q   <= csr.csr_req_idx;
                        wdata_q <= csr.csr_req_wdata;
                        state_q <= EXEC;
                        if (csr.csr_req_wr) begin
                            stable_q <= 1'b0;
                        end
                    end
                end
                EXEC: begin
                    if (!wr_q) begin
                        rdata_q   <= rdata_d;
                        ignored_q <= 1'b0;
                        state_q   <= RSP;
                    end else if (locked_d) begin
                        rdata_q   <= '0;
                        ignored_q <= 1'b1;
                        stable_q  <= 1'b1;
                        state_q   <= RSP;
                    end else begin
                        rdata_q   <= '0;
                        ignored_q <= 1'b0;
                        if (sel_q) begin
                            addr_q[idx_q] <= wdata_q;
                        end else begin
                            cfg_q[idx_q] <= wcfg_d;
                        end
                        state_q <= MASK;
                    end
                end
                MASK: begin
                    // The mask is computed from the just-updated cfg/addr registers of this channel.
                    mask_q[idx_q] <= mask_d;
                    stable_q      <= 1'b1;
                    state_q       <= RSP;
                end
                RSP: begin
                    if (csr.csr_rsp_rdy) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign csr.csr_req_rdy     = (state_q == IDLE);
    assign csr.csr_rsp_vld     = (state_q == RSP);
    assign csr.csr_rsp_rdata   = rdata_q;
    assign csr.csr_rsp_ignored = ignored_q;
    assign v_pmp_cfg           = cfg_q;
    assign v_pmp_addr          = addr_q;
    assign v_pmp_napot_mask    = mask_q;
    assign pmp_cfg_stable      = stable_q;
endmodule

// File: tb/tb_pmp_csr_ctrl.sv
// This bench applies randomized and directed CSR traffic to pmp_csr_ctrl.
// A scoreboard compares the responses and the cfg/addr/mask vectors with an array model of the PMP state.
module tb_pmp_csr_ctrl;
    localparam int N  = 32;
    localparam int AW = 32;
    localparam int IW = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pmp_csr_ctrl_if #(.IDX_W(IW), .ADDR_WIDTH(AW)) bus ();
    logic [N-1:0][7:0]    v_cfg;
    logic [N-1:0][AW-1:0] v_addr;
    logic [N-1:0][AW-1:0] v_mask;
    logic                 stable;

    pmp_csr_ctrl #(.PMP_CHANNEL_NUM(N), .ADDR_WIDTH(AW)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .csr              (bus),
        .v_pmp_cfg        (v_cfg),
        .v_pmp_addr       (v_addr),
        .v_pmp_napot_mask (v_mask),
        .pmp_cfg_stable   (stable)
    );

    typedef struct {
        bit          wr;
        bit          sel;
        int          idx;
        bit          ign;
        logic [31:0] rdata;
        int          lat;
        int          acc;
        logic [31:0] old_mask;
    } exp_t;

    exp_t        q[$];
    logic [7:0]  m_cfg[N];
    logic [31:0] m_addr[N];
    logic [31:0] m_mask[N];
    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    bit          stall = 0;
    logic        last_ign;
    logic [31:0] last_rdata;

    task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", nm, got, exp);
    endtask

    // Mask = all ones above the trailing-ones run of addr and the zero bit that follows it.
    function automatic logic [31:0] napot_mask(logic [7:0] c, logic [31:0] a);
        int t;
        logic [63:0] ones;
        if (c[4:3] == 2'b10) return 32'hFFFF_FFFF;
        t = 0;
        while (t < 32 && a[t]) t++;
        ones = '1;
        ones = ones << (t + 1);
        return ones[31:0];
    endfunction

    function automatic bit model_locked(bit sel, int i);
        if (m_cfg[i][7]) return 1'b1;
        if (sel && i < N - 1 && m_cfg[i+1][7] && m_cfg[i+1][4:3] == 2'b01) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_cfg[i]  = 8'h00;
            m_addr[i] = 32'h0;
            m_mask[i] = 32'hFFFF_FFFF;
        end
    endtask

    task automatic chk_vecs(int focus);
        int c_cfg, c_addr, c_mask;
        c_cfg = focus; c_addr = focus; c_mask = focus;
        for (int i = N - 1; i >= 0; i--) begin
            if (v_cfg[i] !== m_cfg[i]) c_cfg = i;
            if (v_addr[i] !== m_addr[i]) c_addr = i;
            if (v_mask[i] !== m_mask[i]) c_mask = i;
        end
        chk($sformatf("cfg[%0d]", c_cfg), v_cfg[c_cfg], m_cfg[c_cfg]);
        chk($sformatf("addr[%0d]", c_addr), v_addr[c_addr], m_addr[c_addr]);
        chk($sformatf("mask[%0d]", c_mask), v_mask[c_mask], m_mask[c_mask]);
    endtask

    task automatic do_req(bit wr, bit sel, int idx, logic [31:0] wd);
        exp_t e;
        logic [7:0] c;
        int k;
        @(posedge clk); #1;
        k = 0;
        while ((bus.csr_req_rdy !== 1'b1 || q.size() != 0) && k < 200) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 200) begin
            chk("req_accept_timeout", bus.csr_req_rdy, 1);
            return;
        end
        bus.csr_req_vld   = 1'b1;
        bus.csr_req_wr    = wr;
        bus.csr_req_sel   = sel;
        bus.csr_req_idx   = IW'(idx);
        bus.csr_req_wdata = wd;
        e.wr = wr; e.sel = sel; e.idx = idx; e.acc = cyc; e.old_mask = m_mask[idx];
        if (!wr) begin
            e.ign = 1'b0; e.lat = 2;
            e.rdata = sel ? m_addr[idx] : {24'h0, m_cfg[idx]};
        end else begin
            e.rdata = 32'h0;
            e.ign = model_locked(sel, idx);
            e.lat = e.ign ? 2 : 3;
            if (!e.ign) begin
                if (sel) m_addr[idx] = wd;
                else begin
                    c = wd[7:0];
                    c[6:5] = 2'b00;
                    if (c[1] && !c[0]) c[1] = 1'b0;
                    m_cfg[idx] = c;
                end
                m_mask[idx] = napot_mask(m_cfg[idx], m_addr[idx]);
            end
        end
        q.push_back(e);
        @(posedge clk); #1;
        bus.csr_req_vld   = 1'b0;
        bus.csr_req_wdata = $urandom;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (q.size() != 0 && k < 300) begin
            @(posedge clk); #1;
            k++;
        end
        if (k >= 300) begin
            chk("rsp_timeout_pending", q.size(), 0);
            q.delete();
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk); #1;
        bus.csr_rsp_rdy = stall ? 1'b0 : ($urandom_range(0, 3) != 0);
    end

    // The monitor checks response timing, the stable/ready flags and response hold, and it pops the scoreboard on each handshake.
    initial begin
        bit held, ev, erdy, est;
        logic [31:0] h_rdata;
        logic h_ign;
        int d;
        held = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                held = 0;
                continue;
            end
            d = 0;
            if (q.size() > 0) begin
                d = cyc - q[0].acc;
                ev = (d >= q[0].lat);
                erdy = (d == 0);
                est = !(q[0].wr && d >= 1 && d <= (q[0].ign ? 1 : 2));
            end else begin
                ev = 0; erdy = 1; est = 1;
            end
            chk("rsp_vld", bus.csr_rsp_vld, ev);
            chk("req_rdy", bus.csr_req_rdy, erdy);
            chk("cfg_stable", stable, est);
            if (held) begin
                chk("rsp_rdata_hold", bus.csr_rsp_rdata, h_rdata);
                chk("rsp_ignored_hold", bus.csr_rsp_ignored, h_ign);
                held = 0;
            end
            if (q.size() > 0 && q[0].wr && !q[0].ign && d == 2) begin
                chk("cfg_early", v_cfg[q[0].idx], m_cfg[q[0].idx]);
                chk("addr_early", v_addr[q[0].idx], m_addr[q[0].idx]);
                chk("mask_not_yet", v_mask[q[0].idx], q[0].old_mask);
            end
            if (ev) begin
                if (bus.csr_rsp_rdy) begin
                    chk("rsp_rdata", bus.csr_rsp_rdata, q[0].rdata);
                    chk("rsp_ignored", bus.csr_rsp_ignored, q[0].ign);
                    last_rdata = bus.csr_rsp_rdata;
                    last_ign = bus.csr_rsp_ignored;
                    chk_vecs(q[0].idx);
                    void'(q.pop_front());
                end else begin
                    held = 1;
                    h_rdata = bus.csr_rsp_rdata;
                    h_ign = bus.csr_rsp_ignored;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, got running required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit wr, sel;
        int idx, k;
        logic [31:0] r, wd;
        logic [63:0] t, ones;
        logic [7:0] b;
        bus.csr_req_vld = 0; bus.csr_req_wr = 0; bus.csr_req_sel = 0;
        bus.csr_req_idx = '0; bus.csr_req_wdata = '0; bus.csr_rsp_rdy = 0;
        model_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mask0", v_mask[0], 32'hFFFF_FFFF);
        chk("rst_mask_all_ones", &v_mask, 1);
        chk("rst_addr_zero", |v_addr, 0);
        chk("rst_cfg_zero", |v_cfg, 0);
        chk("rst_stable", stable, 1);
        chk("rst_req_rdy", bus.csr_req_rdy, 1);
        chk("rst_rsp_vld", bus.csr_rsp_vld, 0);
        chk("rst_rsp_rdata", bus.csr_rsp_rdata, 0);
        chk("rst_rsp_ignored", bus.csr_rsp_ignored, 0);
        @(negedge clk);
        rst_n = 1'b1;

        do_req(0, 1, 5, 32'h0); wait_idle();
        chk("read_addr5", last_rdata, 32'h0);

        do_req(1, 1, 3, 32'h0000_00FF); wait_idle();
        chk("addr3", v_addr[3], 32'hFF);
        do_req(1, 0, 3, 32'h1F); wait_idle();
        chk("mask3_napot", v_mask[3], 32'hFFFF_FE00);
        chk("cfg3", v_cfg[3], 8'h1F);

        do_req(1, 0, 2, 32'h82); wait_idle();
        chk("cfg2_legalised", v_cfg[2], 8'h80);
        do_req(1, 0, 2, 32'h07); wait_idle();
        chk("cfg2_locked_ign", last_ign, 1);
        chk("cfg2_unchanged", v_cfg[2], 8'h80);
        do_req(1, 1, 2, 32'h1234); wait_idle();
        chk("addr2_locked_ign", last_ign, 1);

        do_req(1, 0, 4, 32'h88); wait_idle();
        do_req(1, 1, 3, 32'h500); wait_idle();
        chk("addr3_tor_ign", last_ign, 1);
        chk("addr3_unchanged", v_addr[3], 32'hFF);
        do_req(1, 1, 4, 32'h600); wait_idle();
        chk("addr4_locked_ign", last_ign, 1);

        do_req(1, 1, 0, 32'hFFFF_FFFF); wait_idle();
        chk("mask0_all_ones_addr", v_mask[0], 32'h0);
        do_req(1, 0, 0, 32'h17); wait_idle();
        chk("mask0_na4", v_mask[0], 32'hFFFF_FFFF);

        stall = 1;
        do_req(0, 1, 3, 32'h0);
        repeat (7) @(posedge clk);
        #1;
        stall = 0;
        wait_idle();
        chk("stall_read_rdata", last_rdata, 32'hFF);

        do_req(1, 1, 6, 32'h77);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        q.delete();
        model_reset();
        chk("arst_rsp_vld", bus.csr_rsp_vld, 0);
        chk("arst_req_rdy", bus.csr_req_rdy, 1);
        chk("arst_stable", stable, 1);
        chk("arst_rsp_rdata", bus.csr_rsp_rdata, 0);
        chk("arst_rsp_ignored", bus.csr_rsp_ignored, 0);
        chk("arst_addr_zero", |v_addr, 0);
        chk("arst_cfg_zero", |v_cfg, 0);
        chk("arst_mask_all_ones", &v_mask, 1);
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_addr6", v_addr[6], 32'h0);

        for (int n = 0; n < 250; n++) begin
            wr  = ($urandom_range(0, 2) != 0);
            sel = $urandom_range(0, 1);
            idx = ($urandom_range(0, 3) == 0) ? $urandom_range(0, N - 1) : $urandom_range(0, 7);
            r = $urandom;
            if (sel) begin
                k = $urandom_range(0, 32);
                t = {32'h0, r} << k;
                ones = (64'h1 << k) - 64'h1;
                wd = ($urandom_range(0, 1) != 0) ? (t[31:0] | ones[31:0]) : r;
            end else begin
                b = r[7:0];
                b[7] = ($urandom_range(0, 7) == 0);
                wd = {r[31:8], b};
            end
            do_req(wr, sel, idx, wd);
        end
        wait_idle();
        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
